plab5_mcore_mem_port_arb: RTL and testbench

PLAB5_MCORE_MEM_PORT_ARB -- requirements
Module: plab5_mcore_mem_port_arb

---
 rtl/plab5_mcore_mem_port_arb.sv | 153 +++++++++++++++
 tb/tb_plab5_mcore_mem_port_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_mem_port_arb.sv
// Two-port memory arbiter: round-robin merges an inst-net (port 0) and a
// data-net (port 1) request stream onto one memory port, and steers the
// in-order memory responses back to the issuing port using a small
// {port, domain} tracking FIFO.
module plab5_mcore_mem_port_arb #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 128,
  parameter int p_max_pending  = 4,
  // Message control widths: type(3) + opaque + addr + len for requests,
  // type(3) + opaque + len for responses; data travels separately.
  localparam int LW = $clog2(p_data_nbits / 8),
  localparam int RC = 3 + p_opaque_nbits + p_addr_nbits + LW,
  localparam int SC = 3 + p_opaque_nbits + LW
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [RC-1:0]           in0_req_control,
  input  logic [p_data_nbits-1:0] in0_req_data,
  input  logic                    in0_req_domain,
  input  logic                    in0_req_val,
  output logic                    in0_req_rdy,

  output logic [SC-1:0]           in0_resp_control,
  output logic [p_data_nbits-1:0] in0_resp_data,
  output logic                    in0_resp_domain,
  output logic                    in0_resp_val,
  input  logic                    in0_resp_rdy,

  input  logic [RC-1:0]           in1_req_control,
  input  logic [p_data_nbits-1:0] in1_req_data,
  input  logic                    in1_req_domain,
  input  logic                    in1_req_val,
  output logic                    in1_req_rdy,

  output logic [SC-1:0]           in1_resp_control,
  output logic [p_data_nbits-1:0] in1_resp_data,
  output logic                    in1_resp_domain,
  output logic                    in1_resp_val,
  input  logic                    in1_resp_rdy,

  output logic [RC-1:0]           mem_req_control,
  output logic [p_data_nbits-1:0] mem_req_data,
  output logic                    mem_req_domain,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,

  input  logic [SC-1:0]           mem_resp_control,
  input  logic [p_data_nbits-1:0] mem_resp_data,
  input  logic                    mem_resp_domain,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,

  output logic                    err_pulse
);

  localparam int PW = (p_max_pending > 1) ? $clog2(p_max_pending) : 1;
  localparam int CW = $clog2(p_max_pending + 1);

  // Tracking state: entry = {port id, request domain}
  logic [1:0]    fifo_q [p_max_pending];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ptr_q, ptr_d;

  logic          full, empty, grant, any_val;
  logic          push, pop;
  logic          head_port, head_dom, dom_ok;

  assign full      = (count_q == CW'(p_max_pending));
  assign empty     = (count_q == '0);
  assign any_val   = in0_req_val | in1_req_val;
  assign head_port = fifo_q[rd_ptr_q][1];
  assign head_dom  = fifo_q[rd_ptr_q][0];
  assign dom_ok    = !empty && (mem_resp_domain == head_dom);

  // Round-robin grant: contention resolved by ptr, a lone requester always wins
  always_comb begin
    grant = in1_req_val;
    if (in0_req_val && in1_req_val) grant = ptr_q;
  end

  // Zero-latency request mux; handshakes suppressed during reset and when full
  always_comb begin
    mem_req_control = grant ? in1_req_control : in0_req_control;
    mem_req_data    = grant ? in1_req_data    : in0_req_data;
    mem_req_domain  = grant ? in1_req_domain  : in0_req_domain;
    mem_req_val     = !reset && any_val && !full;
    in0_req_rdy     = !reset && in0_req_val && !grant && mem_req_rdy && !full;
    in1_req_rdy     = !reset && in1_req_val &&  grant && mem_req_rdy && !full;
  end

  assign push = mem_req_val && mem_req_rdy;

  // Response steering: good responses go to the head port; responses with
  // nothing pending or a wrong domain are swallowed and flagged.
  always_comb begin
    in0_resp_control = mem_resp_control;
    in0_resp_data    = mem_resp_data;
    in0_resp_domain  = mem_resp_domain;
    in1_resp_control = mem_resp_control;
    in1_resp_data    = mem_resp_data;
    in1_resp_domain  = mem_resp_domain;
    in0_resp_val     = !reset && mem_resp_val && dom_ok && !head_port;
    in1_resp_val     = !reset && mem_resp_val && dom_ok &&  head_port;
    mem_resp_rdy     = 1'b0;
    err_pulse        = 1'b0;
    if (!reset) begin
      mem_resp_rdy = dom_ok ? (head_port ? in1_resp_rdy : in0_resp_rdy) : 1'b1;
      err_pulse    = mem_resp_val && !dom_ok;
    end
  end

  assign pop = mem_resp_val && mem_resp_rdy && !empty;

  // Next-state for pointers, occupancy and round-robin priority
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      ptr_d    = !grant;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ptr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
    end
  end

  // Tracking FIFO storage; contents are only meaningful below count_q
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {grant, mem_req_domain};
  end

endmodule

// File: tb/tb_plab5_mcore_mem_port_arb.sv
// Directed bench for plab5_mcore_mem_port_arb at default parameters.
module tb_plab5_mcore_mem_port_arb;

  localparam int RC = 47;
  localparam int SC = 15;
  localparam int L  = 128;

  logic clk = 1'b0;
  logic reset;
  logic [RC-1:0] in0_req_control, in1_req_control, mem_req_control;
  logic [L-1:0]  in0_req_data, in1_req_data, mem_req_data;
  logic          in0_req_domain, in1_req_domain, mem_req_domain;
  logic          in0_req_val, in1_req_val, mem_req_val;
  logic          in0_req_rdy, in1_req_rdy, mem_req_rdy;
  logic [SC-1:0] in0_resp_control, in1_resp_control, mem_resp_control;
  logic [L-1:0]  in0_resp_data, in1_resp_data, mem_resp_data;
  logic          in0_resp_domain, in1_resp_domain, mem_resp_domain;
  logic          in0_resp_val, in1_resp_val, mem_resp_val;
  logic          in0_resp_rdy, in1_resp_rdy, mem_resp_rdy;
  logic          err_pulse;

  int checks = 0;
  int failures = 0;

  localparam logic [L-1:0]  DA  = 128'hA0A0_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [L-1:0]  DB  = 128'hB1B1_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
  localparam logic [L-1:0]  R0  = 128'h0000_0000_0000_0000_0000_0000_0000_0C0C;
  localparam logic [L-1:0]  R1  = 128'hFFFF_0000_0000_0000_0000_0000_0000_0D0D;
  localparam logic [L-1:0]  R2  = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
  localparam logic [RC-1:0] CA  = 47'h1234_5678_9ABC;
  localparam logic [RC-1:0] CB  = 47'h0765_4321_0FED;
  localparam logic [SC-1:0] SCV = 15'h5A3C;

  always #5 clk = ~clk;

  plab5_mcore_mem_port_arb dut (
    .clk(clk), .reset(reset),
    .in0_req_control(in0_req_control), .in0_req_data(in0_req_data),
    .in0_req_domain(in0_req_domain), .in0_req_val(in0_req_val), .in0_req_rdy(in0_req_rdy),
    .in0_resp_control(in0_resp_control), .in0_resp_data(in0_resp_data),
    .in0_resp_domain(in0_resp_domain), .in0_resp_val(in0_resp_val), .in0_resp_rdy(in0_resp_rdy),
    .in1_req_control(in1_req_control), .in1_req_data(in1_req_data),
    .in1_req_domain(in1_req_domain), .in1_req_val(in1_req_val), .in1_req_rdy(in1_req_rdy),
    .in1_resp_control(in1_resp_control), .in1_resp_data(in1_resp_data),
    .in1_resp_domain(in1_resp_domain), .in1_resp_val(in1_resp_val), .in1_resp_rdy(in1_resp_rdy),
    .mem_req_control(mem_req_control), .mem_req_data(mem_req_data),
    .mem_req_domain(mem_req_domain), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_control(mem_resp_control), .mem_resp_data(mem_resp_data),
    .mem_resp_domain(mem_resp_domain), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .err_pulse(err_pulse)
  );

  task automatic chk(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in0_req_control = CA; in0_req_data = DA; in0_req_domain = 1'b0; in0_req_val = 1'b1;
    in1_req_control = CB; in1_req_data = DB; in1_req_domain = 1'b1; in1_req_val = 1'b1;
    in0_resp_rdy = 1'b1; in1_resp_rdy = 1'b1; mem_req_rdy = 1'b1;
    mem_resp_control = SCV; mem_resp_data = R0; mem_resp_domain = 1'b0; mem_resp_val = 1'b1;

    // reset: every handshake output held low despite active inputs
    tick(); tick();
    chk("rst_mem_req_val", L'(mem_req_val), 0);
    chk("rst_in0_req_rdy", L'(in0_req_rdy), 0);
    chk("rst_in1_req_rdy", L'(in1_req_rdy), 0);
    chk("rst_mem_resp_rdy", L'(mem_resp_rdy), 0);
    chk("rst_in0_resp_val", L'(in0_resp_val), 0);
    chk("rst_err_pulse", L'(err_pulse), 0);

    // response with nothing pending is dropped and flagged
    reset = 1'b0; in0_req_val = 1'b0; in1_req_val = 1'b0;
    #1;
    chk("empty_err", L'(err_pulse), 1);
    chk("empty_mem_resp_rdy", L'(mem_resp_rdy), 1);
    chk("empty_in0_resp_val", L'(in0_resp_val), 0);
    chk("empty_in1_resp_val", L'(in1_resp_val), 0);
    tick();
    mem_resp_val = 1'b0;
    #1;
    chk("idle_err", L'(err_pulse), 0);

    // both ports requesting: grants 0,1,0
    in0_req_val = 1'b1; in1_req_val = 1'b1;
    #1;
    chk("rr0_in0_rdy", L'(in0_req_rdy), 1);
    chk("rr0_in1_rdy", L'(in1_req_rdy), 0);
    chk("rr0_mem_val", L'(mem_req_val), 1);
    chk("rr0_data", mem_req_data, DA);
    chk("rr0_ctrl", L'(mem_req_control), L'(CA));
    chk("rr0_dom", L'(mem_req_domain), 0);
    tick();
    chk("rr1_in1_rdy", L'(in1_req_rdy), 1);
    chk("rr1_in0_rdy", L'(in0_req_rdy), 0);
    chk("rr1_data", mem_req_data, DB);
    chk("rr1_ctrl", L'(mem_req_control), L'(CB));
    chk("rr1_dom", L'(mem_req_domain), 1);
    tick();
    chk("rr2_in0_rdy", L'(in0_req_rdy), 1);
    chk("rr2_data", mem_req_data, DA);
    tick();
    // pending: p0/d0, p1/d1, p0/d0 ; ptr prefers port 1

    // lone port 0 requester, memory stalled: no grant, ptr holds
    in1_req_val = 1'b0; mem_req_rdy = 1'b0;
    #1;
    chk("stall_in0_rdy", L'(in0_req_rdy), 0);
    chk("stall_mem_val", L'(mem_req_val), 1);
    tick();
    // lone requester wins despite ptr; simultaneous push and pop
    mem_req_rdy = 1'b1;
    mem_resp_val = 1'b1; mem_resp_domain = 1'b0; mem_resp_data = R0;
    #1;
    chk("lone_in0_rdy", L'(in0_req_rdy), 1);
    chk("resp0_in0_val", L'(in0_resp_val), 1);
    chk("resp0_in1_val", L'(in1_resp_val), 0);
    chk("resp0_data", in0_resp_data, R0);
    chk("resp0_ctrl", L'(in0_resp_control), L'(SCV));
    chk("resp0_mem_rdy", L'(mem_resp_rdy), 1);
    tick();
    // pending: p1/d1, p0/d0, p0/d0
    in0_req_val = 1'b0;
    mem_resp_domain = 1'b1; mem_resp_data = R1;
    #1;
    chk("resp1_in1_val", L'(in1_resp_val), 1);
    chk("resp1_in0_val", L'(in0_resp_val), 0);
    chk("resp1_data", in1_resp_data, R1);
    chk("resp1_dom", L'(in1_resp_domain), 1);
    chk("resp1_err", L'(err_pulse), 0);
    tick();

    // port 0 back-pressure for three cycles holds the response
    mem_resp_domain = 1'b0; mem_resp_data = R2; in0_resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_mem_rdy", L'(mem_resp_rdy), 0);
      chk("bp_in0_val", L'(in0_resp_val), 1);
      tick();
    end
    in0_resp_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", L'(mem_resp_rdy), 1);
    chk("bp_release_data", in0_resp_data, R2);
    tick();
    #1;
    chk("last_in0_val", L'(in0_resp_val), 1);
    tick();
    // now empty
    mem_resp_val = 1'b0;

    // domain mismatch on a port 1 request
    in1_req_val = 1'b1; in1_req_domain = 1'b1;
    #1;
    chk("dm_in1_rdy", L'(in1_req_rdy), 1);
    tick();
    in1_req_val = 1'b0;
    mem_resp_val = 1'b1; mem_resp_domain = 1'b0;
    #1;
    chk("dm_in1_val", L'(in1_resp_val), 0);
    chk("dm_in0_val", L'(in0_resp_val), 0);
    chk("dm_mem_rdy", L'(mem_resp_rdy), 1);
    chk("dm_err", L'(err_pulse), 1);
    tick();
    // entry was popped: the next response finds the FIFO empty
    #1;
    chk("dm_after_empty_err", L'(err_pulse), 1);
    chk("dm_after_in1_val", L'(in1_resp_val), 0);
    mem_resp_val = 1'b0;
    #1;
    chk("dm_err_one_cycle", L'(err_pulse), 0);

    // fill the tracking FIFO from port 0
    in0_req_val = 1'b1; in0_req_domain = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_in0_rdy", L'(in0_req_rdy), 1);
      tick();
    end
    #1;
    chk("full_in0_rdy", L'(in0_req_rdy), 0);
    chk("full_mem_val", L'(mem_req_val), 0);
    tick();
    chk("full_hold_rdy", L'(in0_req_rdy), 0);
    // pop while full: push still blocked this cycle
    mem_resp_val = 1'b1; mem_resp_domain = 1'b0; mem_resp_data = R0;
    #1;
    chk("full_pop_in0_val", L'(in0_resp_val), 1);
    chk("full_pop_in0_rdy", L'(in0_req_rdy), 0);
    chk("full_pop_mem_val", L'(mem_req_val), 0);
    tick();
    mem_resp_val = 1'b0;
    #1;
    chk("unfull_in0_rdy", L'(in0_req_rdy), 1);
    chk("unfull_mem_val", L'(mem_req_val), 1);
    in0_req_val = 1'b0;
    #1;
    tick();
    // three pending entries, ptr prefers port 1

    // reset mid-operation discards pending entries and restores ptr
    reset = 1'b1; in0_req_val = 1'b1; in1_req_val = 1'b1; mem_resp_val = 1'b1;
    #1;
    chk("mid_rst_mem_val", L'(mem_req_val), 0);
    chk("mid_rst_in0_resp_val", L'(in0_resp_val), 0);
    chk("mid_rst_err", L'(err_pulse), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_err", L'(err_pulse), 1);
    chk("post_rst_in0_resp_val", L'(in0_resp_val), 0);
    chk("post_rst_in0_rdy", L'(in0_req_rdy), 1);
    chk("post_rst_in1_rdy", L'(in1_req_rdy), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // safety net against a hung run
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
